seg_display_scanner: RTL
========================

# seg_display_scanner

Multiplexed driver for the board's common-anode 7-segment display, sitting directly downstream of `seg_clock_divider`. It consumes the divider's `clk_out` as a data-level refresh strobe. It does not use it as a clock. It steps one digit per strobe rising edge, decodes a double-buffered hex value to active-low segment/anode drive, and inserts a guard interval against ghosting. New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- `NUM_DIGITS`, 4: digits scanned, valid range 2..8.
- `GUARD_CYCLES`, 2: `clk_in` cycles during which all anodes are off after each digit step, valid range 1..255.
- `LZ_BLANK`, 1: when 1, leading zeros are blanked.
- `clk_in`  in  1: system clock, single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seg_clk`  in  1: refresh strobe from `seg_clock_divider.clk_out`, treated as asynchronous data.
- `load_valid`  in  1: new value offered.
- `load_ready`  out  1: pending buffer empty.
- `load_value`  in  4*NUM_DIGITS: hex nibbles; digit 0 is `[3:0]` (rightmost).
- `load_dp`  in  NUM_DIGITS: decimal-point enables, active high.
- `blank`  in  1: level input; forces all anodes off while high.
- `an`  out  NUM_DIGITS: anode enables, active low.
- `seg`  out  7: {g,f,e,d,c,b,a}, active low.
- `dp_n`  out  1: decimal point, active low.
- `frame_done`  out  1: one-cycle pulse when the digit index wraps to 0.

## Operation
- **Strobe path.**
  - `seg_clk` passes through a 2-flop synchronizer, then a history flop.
  - `tick` = synchronized value high AND history value low.
- **Digit index.** `idx` counts 0..NUM_DIGITS-1 and increments on `tick`, wrapping from NUM_DIGITS-1 to 0. On a wrap tick, `frame_done` = 1.
- **Buffering.**
  - A load is accepted when `load_valid && load_ready`. It writes the pending registers and sets `pend_full`.
  - `load_ready` = !`pend_full`.
  - On a wrap tick with `pend_full` set: the display registers take the pending contents and `pend_full` clears.
  - Load and wrap in the same cycle (only possible while pending is empty): the load goes to pending, and the display is not updated until the next wrap.
- **State machine**, states OFF, GUARD, DRIVE:
  - OFF (reset state): all outputs are off. On `tick`, go to GUARD.
  - GUARD: all outputs are off and the guard counter counts down from GUARD_CYCLES. At zero, go to DRIVE.
  - DRIVE: `an[idx]` = 0, `seg` = decode(display nibble `idx`), `dp_n` = !dp[idx]. On `tick`, go to GUARD and reload the counter.
  - A `tick` while in GUARD reloads the counter and advances `idx`.
- **Leading-zero blanking.** With LZ_BLANK=1, digit i > 0 is blanked (`seg` = 7'h7F) when nibbles i..NUM_DIGITS-1 are all zero. Its anode is still driven, and its dp is still shown. Digit 0 is never blanked.
- **`blank`.** While high, `an` is all ones; the state machine and `idx` keep running.
- **Decode**, active low:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03, C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E

## Timing
- **Reset values:**
  - `an` all ones, `seg` = 7'h7F, `dp_n` = 1.
  - `load_ready` = 1, `frame_done` = 0.
  - `idx` = NUM_DIGITS-1, so the first tick selects digit 0 and is a wrap tick.
  - Display registers = 0, state = OFF.
- **Strobe to tick:** a `seg_clk` rise sampled at edge E produces `tick` high in the cycle after edge E+2. That is 3 `clk_in` cycles of latency, ±1 cycle of synchronizer uncertainty.
- **Tick to drive:** with `tick` in cycle T, the outputs are off in cycles T+1..T+GUARD_CYCLES and driven from T+GUARD_CYCLES+1.
- **Registered outputs:** all outputs are registered, with no combinational path from input to output.
- **Load handshake:** `load_ready` drops in the cycle after acceptance. It rises in the cycle after the wrap tick that drains pending.
- **Reset mid-frame:** asynchronous reset takes effect immediately. A pending value is discarded.

## Structure
- Package `seg_pkg`:
  - constant `SEG_OFF` = 7'h7F
  - function `hex_to_seg(nibble)`
  - state enum {OFF, GUARD, DRIVE}
- Sub-module `seg_tick_sync`: the 2-flop synchronizer plus rising-edge detector, producing the one-cycle `tick`.

## Test plan
- **Reset:** assert `rst_n` low mid-DRIVE → outputs take their reset values immediately; `load_ready` = 1.
- **Load and scan:** load 16'h12AF, then toggle `seg_clk` → over one frame, digits 0..3 show 7'h0E, 7'h08, 7'h24, 7'h79; anode pattern 1110, 1101, 1011, 0111; GUARD_CYCLES all-off cycles before each digit.
- **Leading-zero blanking:** load 16'h0030 with LZ_BLANK=1 → digits 3 and 2 show `seg` 7'h7F with anodes active; digit 1 = 7'h30; digit 0 = 7'h40.
- **Frame-boundary update and backpressure:**
  - Load 16'h1111 mid-frame, then offer 16'h2222 → second offer stalls (`load_ready` = 0).
  - Display remains old until wrap; 16'h1111 appears from digit 0; `frame_done` pulses once.
  - 16'h2222 is accepted the cycle after the wrap.
- **Simultaneous load and wrap:** pending empty, `load_valid` coincides with the wrap tick → value accepted, `frame_done` = 1, display unchanged until the next wrap.
- **`blank` and decimal point:** hold `blank` high for 3 ticks → `an` stays all ones and `idx` still advances. Set `load_dp` = 4'b0100 → `dp_n` = 0 only while digit 2 is driven.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment decoder for the multiplexed 7-segment scanner.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } seg_state_t;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] r;
    case (nibble)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_tick_sync.sv
// Synchronizes the asynchronous refresh strobe and emits a registered one-cycle tick on its rise.
module seg_tick_sync (
  input  logic i_clk_in,
  input  logic i_rst_n,
  input  logic i_seg_clk,
  output logic o_tick
);

  logic r_s1, r_s2, r_hist, r_tick;

  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hist <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= i_seg_clk;
      r_s2   <= r_s1;
      r_hist <= r_s2;
      r_tick <= r_s2 & ~r_hist;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/seg_display_scanner.sv
// Digit-multiplexed 7-segment driver: double-buffered value, frame-boundary updates, anti-ghost guard.
//  state | meaning
//  OFF   | after reset, nothing driven until the first tick
//  GUARD | all anodes off for GUARD_CYCLES after each digit step
//  DRIVE | digit idx driven until the next tick
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      seg_clk,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic                      blank,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp_n,
  output logic                      frame_done
);

  localparam int            IW   = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic                          w_tick, w_wrap, w_accept, w_zrun;
  logic [IW-1:0]                 r_idx;
  seg_state_t                    r_state, w_state_nx;
  logic [7:0]                    r_gcnt;
  logic                          r_pend_full;
  logic [NUM_DIGITS-1:0][3:0]    r_pend_val, r_disp_val;
  logic [NUM_DIGITS-1:0]         r_pend_dp, r_disp_dp, w_lz;
  logic [NUM_DIGITS-1:0]         r_an, w_an_nx;
  logic [6:0]                    r_seg, w_seg_nx;
  logic                          r_dp_n, w_dp_n_nx, r_frame_done;

  seg_tick_sync u_tick_sync (
    .i_clk_in  (clk_in),
    .i_rst_n   (rst_n),
    .i_seg_clk (seg_clk),
    .o_tick    (w_tick)
  );

  assign w_wrap   = w_tick && (r_idx == LAST);
  assign w_accept = load_valid && !r_pend_full;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= OFF;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      OFF:     if (w_tick) w_state_nx = GUARD;
      GUARD:   if (!w_tick && r_gcnt == 8'd1) w_state_nx = DRIVE;
      DRIVE:   if (w_tick) w_state_nx = GUARD;
      default: w_state_nx = OFF;
    endcase
  end

  // A digit is blanked only while it and every digit to its left are zero.
  always_comb begin
    w_lz   = '0;
    w_zrun = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zrun  = w_zrun && (r_disp_val[i] == 4'h0);
      w_lz[i] = w_zrun && (LZ_BLANK != 0);
    end
  end

  // idx and the display buffer only change on a tick, when the next state is GUARD,
  // so decoding from their current values is safe whenever the next state is DRIVE.
  always_comb begin
    w_an_nx   = '1;
    w_seg_nx  = SEG_OFF;
    w_dp_n_nx = 1'b1;
    if (w_state_nx == DRIVE) begin
      w_an_nx[r_idx] = 1'b0;
      w_seg_nx       = w_lz[r_idx] ? SEG_OFF : hex_to_seg(r_disp_val[r_idx]);
      w_dp_n_nx      = ~r_disp_dp[r_idx];
      if (blank) w_an_nx = '1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= LAST;
      r_gcnt       <= '0;
      r_pend_full  <= 1'b0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_an         <= '1;
      r_seg        <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_an         <= w_an_nx;
      r_seg        <= w_seg_nx;
      r_dp_n       <= w_dp_n_nx;
      if (w_tick) begin
        r_idx  <= (r_idx == LAST) ? '0 : r_idx + IW'(1);
        r_gcnt <= 8'(GUARD_CYCLES);
      end else if (r_state == GUARD && r_gcnt != 8'd0) begin
        r_gcnt <= r_gcnt - 8'd1;
      end
      // Accept only happens with pending empty, so it never collides with a drain.
      if (w_accept) begin
        r_pend_full <= 1'b1;
        r_pend_val  <= load_value;
        r_pend_dp   <= load_dp;
      end else if (w_wrap && r_pend_full) begin
        r_pend_full <= 1'b0;
        r_disp_val  <= r_pend_val;
        r_disp_dp   <= r_pend_dp;
      end
    end
  end

  assign load_ready = !r_pend_full;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule
